dma_controller: RTL

DMA_CONTROLLER -- requirements
Module: dma_controller

---
 rtl/dma_controller.sv | 93 +++++++++
 1 files changed

// File: rtl/dma_controller.sv
// Block-mode DMA engine: requests the bus and copies NUM_BLOCKS device blocks
// into consecutive memory blocks, then raises a one-cycle interrupt.
module dma_controller #(
    parameter int unsigned WORD_SIZE   = 16,
    parameter int unsigned BLOCK_WORDS = 4,
    parameter int unsigned NUM_BLOCKS  = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cmd,
    input  logic [WORD_SIZE-1:0]             cmd_addr,
    input  logic                             BG,
    output logic                             BR,
    input  logic [BLOCK_WORDS*WORD_SIZE-1:0] edata,
    output logic [1:0]                       offset,
    output logic                             WRITE,
    output logic [WORD_SIZE-1:0]             addr,
    output logic [BLOCK_WORDS*WORD_SIZE-1:0] data,
    input  logic                             doneM,
    output logic                             interrupt,
    output logic                             busy
);

    typedef enum logic [1:0] {StIdle, StReq, StXfer, StFin} state_e;

    localparam logic [1:0]           LastOffset = 2'(NUM_BLOCKS - 1);
    localparam logic [WORD_SIZE-1:0] Stride     = WORD_SIZE'(BLOCK_WORDS);

    state_e               state_q, state_d;
    logic [WORD_SIZE-1:0] base_q, base_d;
    logic [1:0]           offset_q, offset_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            base_q   <= '0;
            offset_q <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            offset_q <= offset_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        offset_d  = offset_q;
        BR        = 1'b0;
        WRITE     = 1'b0;
        addr      = '0;
        data      = '0;
        offset    = '0;
        interrupt = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd) begin
                    base_d   = cmd_addr;
                    offset_d = '0;
                    state_d  = StReq;
                end
            end
            StReq: begin
                BR     = 1'b1;
                busy   = 1'b1;
                offset = offset_q;
                if (BG) state_d = StXfer;
            end
            StXfer: begin
                BR     = 1'b1;
                busy   = 1'b1;
                offset = offset_q;
                WRITE  = BG;
                // Address wraps naturally at WORD_SIZE bits.
                addr   = base_q + WORD_SIZE'(offset_q) * Stride;
                data   = edata;
                if (BG && doneM) begin
                    if (offset_q == LastOffset) state_d = StFin;
                    else                        offset_d = offset_q + 2'd1;
                end
            end
            StFin: begin
                busy      = 1'b1;
                interrupt = 1'b1;
                offset    = offset_q;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
